// File: rtl/mem_arb_pkg.sv
// Shared definitions for the external-memory arbiter: FSM state encoding and
// default bus widths.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 7;
   localparam int DEF_DATA_W = 8;

   // Bus-cycle sequencer states.
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE   = 2'd0;
   localparam state_t S_SETUP  = 2'd1;
   localparam state_t S_STROBE = 2'd2;
   localparam state_t S_HOLD   = 2'd3;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker. Purely combinational: a lone requester wins,
// a tie goes to the port that was not granted last.
module mem_arb_rr (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic grant_o,
   output logic valid_o
);

   assign valid_o = req0_i | req1_i;
   assign grant_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one asynchronous memory bus between two requesters. Each access runs
// IDLE -> SETUP -> STROBE (WAIT_CYCLES clocks) -> HOLD, with every bus output
// registered so no request input reaches the pins combinationally.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] address_bus,
   inout  wire  [DATA_W-1:0] data_bus,
   output logic              read_n,
   output logic              write_n
);

   localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_q, grant_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                drive_q, drive_d;
   logic                read_n_q, read_n_d;
   logic                write_n_q, write_n_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;

   logic                arb_grant;
   logic                arb_valid;

   mem_arb_rr u_rr (
      .req0_i       (req0),
      .req1_i       (req1),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant),
      .valid_o      (arb_valid)
   );

   // Next-state and datapath logic for the bus-cycle sequencer.
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned,
      // which is what keeps this block from inferring latches.
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      drive_d      = drive_q;
      read_n_d     = read_n_q;
      write_n_d    = write_n_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;

      case (state_q)
         S_IDLE: begin
            if (arb_valid) begin
               grant_d      = arb_grant;
               last_grant_d = arb_grant;
               we_d         = arb_grant ? we1    : we0;
               addr_d       = arb_grant ? addr1  : addr0;
               wdata_d      = arb_grant ? wdata1 : wdata0;
               // Write data goes out together with the address in SETUP.
               drive_d      = arb_grant ? we1    : we0;
               state_d      = S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_d     = '0;
            read_n_d  = we_q;
            write_n_d = ~we_q;
            state_d   = S_STROBE;
         end
         S_STROBE: begin
            if (cnt_q == CNT_LAST) begin
               read_n_d  = 1'b1;
               write_n_d = 1'b1;
               ack0_d    = ~grant_q;
               ack1_d    = grant_q;
               // Memory data is sampled while read_n is still low.
               if (!we_q) begin
                  if (grant_q) rdata1_d = data_bus;
                  else         rdata0_d = data_bus;
               end
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            drive_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: the address/data holding registers are reset too, so the bus
      // pins come out of reset at defined values rather than stale contents.
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         drive_q      <= 1'b0;
         read_n_q     <= 1'b1;
         write_n_q    <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         drive_q      <= drive_d;
         read_n_q     <= read_n_d;
         write_n_q    <= write_n_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign address_bus = addr_q;
   assign data_bus    = drive_q ? wdata_q : {DATA_W{1'bz}};
   assign read_n      = read_n_q;
   assign write_n     = write_n_q;
   assign ack0        = ack0_q;
   assign ack1        = ack1_q;
   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances (WAIT_CYCLES=2 and 1), each
// on its own behavioural memory preloaded with mem[a] = a ^ 0x5A.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       req0 [2], req1 [2], we0 [2], we1 [2];
   logic [6:0] addr0 [2], addr1 [2];
   logic [7:0] wdata0 [2], wdata1 [2];
   logic       ack0 [2], ack1 [2];
   logic [7:0] rdata0 [2], rdata1 [2];
   logic [6:0] abus [2];
   logic       rd_n [2], wr_n [2];
   wire  [7:0] db0, db1;

   logic [7:0] mem0 [128];
   logic [7:0] mem1 [128];

   // Memory drives the bus only while its read strobe is low.
   assign db0 = rd_n[0] ? 8'bz : mem0[abus[0]];
   assign db1 = rd_n[1] ? 8'bz : mem1[abus[1]];

   mem_arbiter #(.WAIT_CYCLES(2)) u_dut0 (
      .clk(clk), .reset(reset),
      .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
      .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
      .ack0(ack0[0]), .ack1(ack1[0]), .rdata0(rdata0[0]), .rdata1(rdata1[0]),
      .address_bus(abus[0]), .data_bus(db0), .read_n(rd_n[0]), .write_n(wr_n[0])
   );

   mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
      .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
      .ack0(ack0[1]), .ack1(ack1[1]), .rdata0(rdata0[1]), .rdata1(rdata1[1]),
      .address_bus(abus[1]), .data_bus(db1), .read_n(rd_n[1]), .write_n(wr_n[1])
   );

   // Preload, then capture writes on every edge where write_n is low.
   initial begin
      for (int i = 0; i < 128; i++) begin
         mem0[i] = 8'(i) ^ 8'h5A;
         mem1[i] = 8'(i) ^ 8'h5A;
      end
      forever begin
         @(posedge clk);
         if (!reset && !wr_n[0]) mem0[abus[0]] = db0;
         if (!reset && !wr_n[1]) mem1[abus[1]] = db1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         port;
      bit         rd;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       sbq0 [$];
   exp_t       sbq1 [$];
   logic [7:0] mdl_rdata [2][2];
   int         total = 0;
   int         bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int d, input bit p, input bit rd, input logic [7:0] data, input int c);
      exp_t e;
      e.port = p; e.rd = rd; e.data = data; e.cyc = c;
      if (d == 0) sbq0.push_back(e);
      else        sbq1.push_back(e);
   endtask

   task automatic sb_pop(input int d);
      exp_t e;
      int   n;
      n = (d == 0) ? sbq0.size() : sbq1.size();
      check("acks_exclusive", ack0[d] & ack1[d], 1'b0);
      if (n == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_ack: dut%0d ack0=%0b ack1=%0b with no access pending", d, ack0[d], ack1[d]);
      end else begin
         e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
         check("ack_port", ack1[d], e.port);
         check("ack_cycle", cyc, e.cyc);
         if (e.rd) mdl_rdata[d][e.port] = e.data;
         check("rdata0", rdata0[d], mdl_rdata[d][0]);
         check("rdata1", rdata1[d], mdl_rdata[d][1]);
      end
   endtask

   // Monitor: every ack pops one expected response.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++)
         if (ack0[d] || ack1[d]) sb_pop(d);
   end

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) mdl_rdata[d][p] = 8'h00;
   endtask

   // Single access on one port; checks bus contents and strobe widths.
   // The ack is seen on the negedge after edge k+w+1, i.e. the edge k+w+2
   // is the first to capture it.
   task automatic do_access(input int d, input bit p, input bit we, input logic [6:0] a,
                            input logic [7:0] wd, input logic [7:0] exp_rd, input int w);
      int k, nrd, nwr;
      bit got;
      @(negedge clk);
      if (p) begin we1[d] = we; addr1[d] = a; wdata1[d] = wd; req1[d] = 1'b1; end
      else   begin we0[d] = we; addr0[d] = a; wdata0[d] = wd; req0[d] = 1'b1; end
      k = cyc + 1;
      push(d, p, !we, exp_rd, k + w + 1);
      nrd = 0; nwr = 0; got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (!rd_n[d]) nrd++;
         if (!wr_n[d]) nwr++;
         if (cyc == k || (p ? ack1[d] : ack0[d])) begin
            check("address_bus", abus[d], a);
            if (we) check("data_bus", (d == 0) ? db0 : db1, wd);
         end
         if (p ? ack1[d] : ack0[d]) begin
            got = 1'b1;
            if (p) req1[d] = 1'b0; else req0[d] = 1'b0;
         end
      end
      check("ack_seen", got, 1'b1);
      check("read_n_width", nrd, we ? 0 : w);
      check("write_n_width", nwr, we ? w : 0);
   endtask

   initial begin
      int k, n;
      for (int d = 0; d < 2; d++) begin
         req0[d] = 0; req1[d] = 0; we0[d] = 0; we1[d] = 0;
         addr0[d] = 0; addr1[d] = 0; wdata0[d] = 0; wdata1[d] = 0;
      end
      clear_model();

      // Reset values.
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_read_n", rd_n[d], 1'b1);
         check("rst_write_n", wr_n[d], 1'b1);
         check("rst_address", abus[d], 7'h00);
         check("rst_acks", {ack0[d], ack1[d]}, 2'b00);
         check("rst_rdata", {rdata0[d], rdata1[d]}, 16'h0000);
      end
      reset = 1'b0;

      // Port 0 write, then port 1 reads it back.
      do_access(0, 1'b0, 1'b1, 7'h15, 8'hA5, 8'h00, 2);
      do_access(0, 1'b1, 1'b0, 7'h15, 8'h00, 8'hA5, 2);

      // Both ports request continuously from reset: order 0,1,0,1, 5 clks apart.
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      clear_model();
      we0[0] = 0; addr0[0] = 7'h10; req0[0] = 1'b1;
      we1[0] = 0; addr1[0] = 7'h11; req1[0] = 1'b1;
      reset = 1'b0;
      k = cyc + 1;
      push(0, 1'b0, 1'b1, 8'h4A, k + 3);
      push(0, 1'b1, 1'b1, 8'h4B, k + 8);
      push(0, 1'b0, 1'b1, 8'h4A, k + 13);
      push(0, 1'b1, 1'b1, 8'h4B, k + 18);
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (ack0[0] || ack1[0]) begin
            n++;
            if (n == 3) req0[0] = 1'b0;
            if (n == 4) req1[0] = 1'b0;
         end
      end
      req0[0] = 1'b0; req1[0] = 1'b0;
      check("rr_ack_count", n, 4);

      // Reset during the first STROBE clock of a port 0 write.
      @(negedge clk);
      we0[0] = 1'b1; addr0[0] = 7'h20; wdata0[0] = 8'h77; req0[0] = 1'b1;
      @(negedge clk);
      check("abort_setup_data", db0, 8'h77);
      @(negedge clk);
      check("abort_strobe_low", wr_n[0], 1'b0);
      reset = 1'b1;
      @(negedge clk);
      clear_model();
      check("abort_write_n", wr_n[0], 1'b1);
      check("abort_read_n", rd_n[0], 1'b1);
      check("abort_address", abus[0], 7'h00);
      check("abort_ack", {ack0[0], ack1[0]}, 2'b00);
      reset = 1'b0; req0[0] = 1'b0; we0[0] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("abort_quiet", {rd_n[0], wr_n[0], ack0[0], ack1[0]}, 4'b1100);
      end
      do_access(0, 1'b1, 1'b0, 7'h15, 8'h00, 8'hA5, 2);

      // WAIT_CYCLES=1: four back-to-back reads, one ack every 4 clks.
      @(negedge clk);
      we0[1] = 1'b0; addr0[1] = 7'h00; req0[1] = 1'b1;
      k = cyc + 1;
      push(1, 1'b0, 1'b1, 8'h5A, k + 2);
      push(1, 1'b0, 1'b1, 8'h5B, k + 6);
      push(1, 1'b0, 1'b1, 8'h58, k + 10);
      push(1, 1'b0, 1'b1, 8'h59, k + 14);
      n = 0;
      for (int i = 0; i < 30 && n < 4; i++) begin
         @(negedge clk);
         if (ack0[1]) begin
            n++;
            addr0[1] = 7'(n);
            if (n == 4) req0[1] = 1'b0;
         end
      end
      req0[1] = 1'b0;
      check("b2b_ack_count", n, 4);

      // Port 0 drops req during STROBE: access completes, no second access.
      @(negedge clk);
      we0[0] = 1'b0; addr0[0] = 7'h11; req0[0] = 1'b1;
      k = cyc + 1;
      push(0, 1'b0, 1'b1, 8'h4B, k + 3);
      @(negedge clk);
      @(negedge clk);
      req0[0] = 1'b0;
      n = 0;
      for (int i = 0; i < 10 && n == 0; i++) begin
         @(negedge clk);
         if (ack0[0]) n++;
      end
      check("drop_ack_seen", n, 1);
      repeat (8) begin
         @(negedge clk);
         check("drop_no_reaccess", {rd_n[0], wr_n[0], ack0[0], ack1[0]}, 4'b1100);
      end

      check("sb0_drained", sbq0.size(), 0);
      check("sb1_drained", sbq1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
